crack_range: RTL and testbench
==============================

// Module: crack_range
// PURPOSE
// Parametrised ARC4 key-search controller. Walks candidate keys from start_key to last_key in steps of stride.
// For each candidate it runs an external arc4 core, then scans the length-prefixed plaintext buffer for bytes in [CHAR_LO,CHAR_HI].
// Several instances with interleaved start/stride split one keyspace; the top level arbitrates results.
// Adds over the previous cracker: configurable width and char window, inclusive end key, abort, a done/exhausted result and a keys-tried count.
// PARAMETERS
// KEY_W    24     candidate key width; also width of a4_key, start_key, stride, last_key
// ADDR_W   8      plaintext memory address width; the length byte is at address 0
// CNT_W    32     width of keys_tried
// CHAR_LO  8'h20  lowest acceptable plaintext byte
// CHAR_HI  8'h7E  highest acceptable plaintext byte
// PORTS
// clk          in   1       clock
// rst_n        in   1       asynchronous active-low reset
// en           in   1       start request; accepted when en & rdy
// rdy          out  1       idle, ready to accept en
// start_key    in   KEY_W   first candidate, sampled on accept
// stride       in   KEY_W   candidate increment, sampled on accept; 0 is treated as 1
// last_key     in   KEY_W   inclusive final candidate, sampled on accept
// abort        in   1       stop the search; ignored in IDLE
// key          out  KEY_W   winning key; 0 unless key_valid
// key_valid    out  1       the last search found a key
// done         out  1       the last search ended (found, exhausted or aborted)
// keys_tried   out  CNT_W   candidates fully evaluated in the current or last search; saturates
// a4_en        out  1       arc4 start; the core accepts on a4_en & a4_rdy
// a4_rdy       in   1       arc4 idle
// a4_key       out  KEY_W   current candidate, held stable while not IDLE
// mem_addr     out  ADDR_W  plaintext memory address; read data is returned 1 cycle later
// mem_rddata   in   8       plaintext memory read data
// host_addr    in   ADDR_W  host read address, forwarded to mem_addr only in IDLE
// host_rddata  out  8       mem_rddata in IDLE, else 0
// BEHAVIOUR
// - Reset values: state IDLE, rdy=1, key_valid=0, done=0, keys_tried=0, a4_en=0, cand=0, idx=0, len=0.
// - rdy=(state==IDLE). When state != IDLE, mem_addr is driven from the FSM and host_addr is ignored.
// - IDLE: on en, load cand=start_key, stp=(stride==0)?1:stride and end_key=last_key.
//   - Same edge: clear key_valid, done and keys_tried, then go to START.
// - START: a4_en=1. When a4_rdy=1 in the same cycle, go to BUSY; otherwise hold a4_en until the core is ready.
// - BUSY: wait for a4_rdy=0, then go to RUN.
// - RUN: wait for a4_rdy=1, then go to LEN0.
// - LEN0: mem_addr=0, then go to LEN1.
// - LEN1: len=mem_rddata, idx=1. If len==0, go to FOUND; else go to RD0.
// - RD0: mem_addr=idx, then go to RD1.
// - RD1: the byte b=mem_rddata is checked.
//   - b<CHAR_LO or b>CHAR_HI: go to NEXT.
//   - b is in range and idx==len: go to FOUND.
//   - Otherwise: idx<=idx+1, go to RD0.
// - NEXT: keys_tried+1 (saturating). sum = {1'b0,cand}+stp computed in KEY_W+1 bits.
//   - cand==end_key, or sum carries, or sum>end_key: done=1, key_valid=0, go to IDLE (exhausted).
//   - Otherwise: cand<=sum, go to START.
// - FOUND: keys_tried+1, key_valid=1, done=1, go to IDLE. key=cand while key_valid is 1.
// - Outer loop: each candidate runs START -> BUSY -> RUN -> LEN0 -> LEN1 -> (RD0/RD1 per byte) -> NEXT or FOUND.
// - Latency per rejected key = 2 (START/BUSY, minimum) + arc4 run + 2 (LEN0/LEN1) + 2 per checked byte + 1 (NEXT).
// - Abort in any non-IDLE state: next state is IDLE, done=1, key_valid=0, and keys_tried is not incremented.
//   - Abort wins over a simultaneous FOUND or NEXT.
//   - A running arc4 core is left to finish; the next START waits on a4_rdy.
// - start_key>last_key: the first candidate is still evaluated, then the search exhausts in NEXT.
// - en while not IDLE is ignored. done, key and key_valid hold until the next accepted en.
// - An async reset mid-search returns to IDLE immediately; a4_en drops in the same cycle.
// TESTING
// - Arc4 model, plaintext [3,'a','b','c'] on start_key=5 only; start=0, stride=1, last=10 -> key=5, key_valid=1, done=1, keys_tried=6.
// - Every plaintext contains byte 8'h7F; start=0, stride=1, last=3 -> done=1, key_valid=0, keys_tried=4, rdy=1.
// - start=2, stride=4, last=14 with the winner at 10 -> candidates 2,6,10 visited, key=10, keys_tried=3.
// - stride=0 -> behaves as stride=1.
// - start=FFFFFE, stride=3, last=FFFFFF -> one candidate, overflow detected, exhausted, keys_tried=1.
// - Length byte 0 -> FOUND on the first candidate with no RD0/RD1 cycles.
// - abort pulse in RUN -> IDLE next cycle, done=1, key_valid=0, keys_tried unchanged.
// - Host read in IDLE: host_addr=2 -> host_rddata='b' 1 cycle later. While not IDLE, host_rddata=0.
// - rst_n low during RD1 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/crack_range.sv
// ARC4 key-search controller: walks start_key..last_key by stride, runs the arc4
// core per candidate and accepts the first plaintext whose bytes all lie in [CHAR_LO,CHAR_HI].
module crack_range #(
  parameter int         KEY_W   = 24,
  parameter int         ADDR_W  = 8,
  parameter int         CNT_W   = 32,
  parameter logic [7:0] CHAR_LO = 8'h20,
  parameter logic [7:0] CHAR_HI = 8'h7E
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  start_key,
  input  logic [KEY_W-1:0]  stride,
  input  logic [KEY_W-1:0]  last_key,
  input  logic              abort,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic              done,
  output logic [CNT_W-1:0]  keys_tried,
  output logic              a4_en,
  input  logic              a4_rdy,
  output logic [KEY_W-1:0]  a4_key,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rddata,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rddata
);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_BUSY, S_RUN, S_LEN0, S_LEN1, S_RD0, S_RD1, S_NEXT, S_FOUND
  } state_t;

  localparam int CW = (ADDR_W > 8) ? ADDR_W : 8;

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  cand_q, cand_d;
  logic [KEY_W-1:0]  stp_q, stp_d;
  logic [KEY_W-1:0]  end_q, end_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        len_q, len_d;
  logic              kv_q, kv_d;
  logic              done_q, done_d;
  logic              a4_en_q, a4_en_d;
  logic [CNT_W-1:0]  tried_q, tried_d, tried_inc;
  logic [KEY_W:0]    sum;
  logic              byte_ok, last_byte;

  // Extra top bit catches a wrap past the end of the keyspace.
  assign sum       = {1'b0, cand_q} + {1'b0, stp_q};
  assign byte_ok   = (mem_rddata >= CHAR_LO) && (mem_rddata <= CHAR_HI);
  assign last_byte = CW'(idx_q) == CW'(len_q);
  assign tried_inc = (&tried_q) ? tried_q : tried_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stp_d   = stp_q;
    end_d   = end_q;
    idx_d   = idx_q;
    len_d   = len_q;
    kv_d    = kv_q;
    done_d  = done_q;
    tried_d = tried_q;
    case (state_q)
      S_IDLE: if (en) begin
        cand_d  = start_key;
        stp_d   = (stride == '0) ? KEY_W'(1) : stride;
        end_d   = last_key;
        kv_d    = 1'b0;
        done_d  = 1'b0;
        tried_d = '0;
        state_d = S_START;
      end
      S_START: if (a4_rdy) state_d = S_BUSY;
      S_BUSY:  if (!a4_rdy) state_d = S_RUN;
      S_RUN:   if (a4_rdy) state_d = S_LEN0;
      S_LEN0:  state_d = S_LEN1;
      S_LEN1: begin
        len_d   = mem_rddata;
        idx_d   = ADDR_W'(1);
        state_d = (mem_rddata == 8'h00) ? S_FOUND : S_RD0;
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        if (!byte_ok)       state_d = S_NEXT;
        else if (last_byte) state_d = S_FOUND;
        else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_RD0;
        end
      end
      S_NEXT: begin
        tried_d = tried_inc;
        if (cand_q == end_q || sum[KEY_W] || sum[KEY_W-1:0] > end_q) begin
          done_d  = 1'b1;
          kv_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cand_d  = sum[KEY_W-1:0];
          state_d = S_START;
        end
      end
      S_FOUND: begin
        tried_d = tried_inc;
        kv_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides whatever the current state decided, including FOUND/NEXT.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      kv_d    = 1'b0;
      tried_d = tried_q;
      cand_d  = cand_q;
    end
    a4_en_d = (state_d == S_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      stp_q   <= '0;
      end_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
      a4_en_q <= 1'b0;
      tried_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stp_q   <= stp_d;
      end_q   <= end_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
      a4_en_q <= a4_en_d;
      tried_q <= tried_d;
    end
  end

  assign rdy         = (state_q == S_IDLE);
  assign key         = kv_q ? cand_q : '0;
  assign key_valid   = kv_q;
  assign done        = done_q;
  assign keys_tried  = tried_q;
  assign a4_en       = a4_en_q;
  assign a4_key      = cand_q;
  assign mem_addr    = rdy ? host_addr : ((state_q == S_RD0) ? idx_q : '0);
  assign host_rddata = rdy ? mem_rddata : 8'h00;
endmodule

// File: tb/tb_crack_range.sv
// Bench for crack_range: arc4/memory model that writes a key-dependent plaintext,
// and a keyspace-walk reference model that predicts winner and keys tried.
module tb_crack_range;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, abort = 1'b0;
  logic        rdy, key_valid, done, a4_en;
  logic        a4_rdy = 1'b1;
  logic [23:0] start_key = '0, stride = '0, last_key = '0, key, a4_key;
  logic [31:0] keys_tried;
  logic [7:0]  mem_addr, host_rddata;
  logic [7:0]  host_addr = '0, mem_rddata = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  crack_range #(.KEY_W(24), .ADDR_W(8), .CNT_W(32), .CHAR_LO(8'h20), .CHAR_HI(8'h7E)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .start_key(start_key), .stride(stride),
    .last_key(last_key), .abort(abort), .key(key), .key_valid(key_valid), .done(done),
    .keys_tried(keys_tried), .a4_en(a4_en), .a4_rdy(a4_rdy), .a4_key(a4_key),
    .mem_addr(mem_addr), .mem_rddata(mem_rddata), .host_addr(host_addr), .host_rddata(host_rddata));

  // Plaintext world: the winner (or every key in zero_len mode) decrypts cleanly,
  // every other key gets a plaintext with exactly one out-of-window byte.
  logic [7:0]  mem [0:255];
  logic [7:0]  win_pt [0:15];
  logic [23:0] win_key = '0, cur = '0;
  bit          win_en = 0, zero_len = 0, force7f = 0;
  int unsigned seed = 0;
  int          run_len = 2, run_cnt = 0;
  logic [23:0] visited [$];

  function automatic logic [7:0] pt_byte(logic [23:0] k, int a);
    int unsigned h, h2, n, bad;
    if (zero_len) return (a == 0) ? 8'h00 : 8'h41;
    if (win_en && k == win_key) return (a < 16) ? win_pt[a] : 8'h00;
    h  = (32'(k) ^ seed) * 32'h9E3779B1; h ^= h >> 15;
    n  = 1 + h % 6;
    bad = 1 + (h >> 4) % n;
    h2 = h + 32'(a) * 32'h85EBCA6B; h2 ^= h2 >> 13;
    if (a == 0) return 8'(n);
    if (a == int'(bad))
      return force7f ? 8'h7F : (((h >> 9) & 1) != 0) ? 8'((h >> 10) % 32) : 8'(32'h7F + (h >> 10) % 129);
    return 8'(32'h20 + h2 % 95);
  endfunction

  function automatic bit key_good(logic [23:0] k);
    return zero_len || (win_en && k == win_key);
  endfunction

  // Walk the keyspace exactly as described: each candidate counts, stop on a
  // good key, or when the candidate was the last one or the next would pass it.
  function automatic void ref_search(input logic [23:0] s, st, l,
                                     output bit f, output logic [23:0] k, output int tried);
    logic [24:0] c, nx;
    logic [23:0] stp;
    stp = (st == 0) ? 24'd1 : st;
    c = {1'b0, s}; f = 0; k = '0; tried = 0;
    while (tried < 100000) begin
      tried++;
      if (key_good(c[23:0])) begin f = 1; k = c[23:0]; return; end
      nx = c + {1'b0, stp};
      if (c[23:0] == l || nx > {1'b0, l}) return;
      c = nx;
    end
  endfunction

  always @(posedge clk) begin
    if (a4_en && a4_rdy) begin
      a4_rdy  <= 1'b0;
      run_cnt <= run_len;
      cur     <= a4_key;
      visited.push_back(a4_key);
    end else if (!a4_rdy) begin
      if (run_cnt == 0) begin
        for (int a = 0; a < 256; a++) mem[a] <= pt_byte(cur, a);
        a4_rdy <= 1'b1;
      end else run_cnt <= run_cnt - 1;
    end
  end

  always @(posedge clk) mem_rddata <= mem[mem_addr];

  task automatic set_win_abc(input logic [23:0] k);
    win_en = 1; win_key = k;
    win_pt[0] = 8'd3; win_pt[1] = "a"; win_pt[2] = "b"; win_pt[3] = "c";
  endtask

  task automatic run_search(input logic [23:0] s, st, l, output int rd_cyc);
    int n = 0;
    bit hz_bad = 0;
    rd_cyc = 0;
    while (!rdy && n < 20000) begin @(negedge clk); n++; end
    visited.delete();
    start_key = s; stride = st; last_key = l; en = 1;
    @(negedge clk); en = 0;
    while (!(rdy && done) && n < 20000) begin
      if (!rdy && host_rddata !== 8'h00) hz_bad = 1;
      if (!rdy && mem_addr != 0) rd_cyc++;
      @(negedge clk); n++;
    end
    checks += 2;
    if (n >= 20000) begin errors++; $display("FAIL search_timeout: start %h got no done within %0d cycles", s, n); end
    if (hz_bad) begin errors++; $display("FAIL host_zero_busy: host_rddata nonzero while busy, want 00"); end
  endtask

  task automatic test_reset;
    checks += 6;
    if (rdy !== 1'b1)          begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (key_valid !== 1'b0)    begin errors++; $display("FAIL reset_kv: got %b want 0", key_valid); end
    if (keys_tried !== 32'd0)  begin errors++; $display("FAIL reset_tried: got %0d want 0", keys_tried); end
    if (a4_en !== 1'b0)        begin errors++; $display("FAIL reset_a4en: got %b want 0", a4_en); end
    if (key !== 24'd0)         begin errors++; $display("FAIL reset_key: got %h want 0", key); end
  endtask

  task automatic test_found;
    int rd;
    zero_len = 0; force7f = 0; seed = $urandom; run_len = 3;
    set_win_abc(24'd5);
    run_search(24'd0, 24'd1, 24'd10, rd);
    checks += 4;
    if (key !== 24'd5)        begin errors++; $display("FAIL found_key: got %h want 5", key); end
    if (key_valid !== 1'b1)   begin errors++; $display("FAIL found_kv: got %b want 1", key_valid); end
    if (done !== 1'b1)        begin errors++; $display("FAIL found_done: got %b want 1", done); end
    if (keys_tried !== 32'd6) begin errors++; $display("FAIL found_tried: got %0d want 6", keys_tried); end
  endtask

  task automatic test_host_read;
    @(negedge clk); host_addr = 8'd2;
    @(negedge clk);
    checks++;
    if (host_rddata !== 8'h62) begin errors++; $display("FAIL host_read_2: got %h want 62", host_rddata); end
    host_addr = 8'd3;
    @(negedge clk);
    checks++;
    if (host_rddata !== 8'h63) begin errors++; $display("FAIL host_read_3: got %h want 63", host_rddata); end
    host_addr = 8'd0;
  endtask

  task automatic test_exhaust;
    int rd;
    win_en = 0; force7f = 1; seed = $urandom; run_len = 1;
    run_search(24'd0, 24'd1, 24'd3, rd);
    checks += 4;
    if (done !== 1'b1)        begin errors++; $display("FAIL exhaust_done: got %b want 1", done); end
    if (key_valid !== 1'b0)   begin errors++; $display("FAIL exhaust_kv: got %b want 0", key_valid); end
    if (keys_tried !== 32'd4) begin errors++; $display("FAIL exhaust_tried: got %0d want 4", keys_tried); end
    if (rdy !== 1'b1)         begin errors++; $display("FAIL exhaust_rdy: got %b want 1", rdy); end
    force7f = 0;
  endtask

  task automatic test_stride;
    int rd;
    seed = $urandom; run_len = 2;
    set_win_abc(24'd10);
    fork
      run_search(24'd2, 24'd4, 24'd14, rd);
      begin // a stray en mid-search must be ignored
        repeat (8) @(negedge clk);
        start_key = 24'd0; en = 1; @(negedge clk); en = 0;
      end
    join
    checks += 3;
    if (key !== 24'd10) begin errors++; $display("FAIL stride_key: got %h want 10", key); end
    if (keys_tried !== 32'd3) begin errors++; $display("FAIL stride_tried: got %0d want 3", keys_tried); end
    if (visited.size() != 3 || visited[0] != 24'd2 || visited[1] != 24'd6 || visited[2] != 24'd10) begin
      errors++; $display("FAIL stride_visited: got %0d keys first %h want 2,6,10", visited.size(),
                         (visited.size() > 0) ? visited[0] : 24'hx);
    end
    set_win_abc(24'd7);
    run_search(24'd3, 24'd0, 24'd20, rd);
    checks += 2;
    if (key !== 24'd7)        begin errors++; $display("FAIL stride0_key: got %h want 7", key); end
    if (keys_tried !== 32'd5) begin errors++; $display("FAIL stride0_tried: got %0d want 5", keys_tried); end
  endtask

  task automatic test_boundaries;
    int rd;
    win_en = 0; seed = $urandom; run_len = 0;
    run_search(24'hFFFFFE, 24'd3, 24'hFFFFFF, rd);
    checks += 3;
    if (keys_tried !== 32'd1) begin errors++; $display("FAIL ovf_tried: got %0d want 1", keys_tried); end
    if (key_valid !== 1'b0)   begin errors++; $display("FAIL ovf_kv: got %b want 0", key_valid); end
    if (done !== 1'b1)        begin errors++; $display("FAIL ovf_done: got %b want 1", done); end
    run_search(24'd10, 24'd1, 24'd5, rd);
    checks++;
    if (keys_tried !== 32'd1 || key_valid !== 1'b0) begin
      errors++; $display("FAIL start_gt_last: got tried %0d kv %b want 1 0", keys_tried, key_valid);
    end
    zero_len = 1;
    run_search(24'd9, 24'd1, 24'd50, rd);
    checks += 3;
    if (key !== 24'd9 || key_valid !== 1'b1) begin errors++; $display("FAIL zlen_key: got %h kv %b want 9 1", key, key_valid); end
    if (keys_tried !== 32'd1) begin errors++; $display("FAIL zlen_tried: got %0d want 1", keys_tried); end
    if (rd != 0)              begin errors++; $display("FAIL zlen_no_rd: got %0d byte reads want 0", rd); end
    zero_len = 0;
  endtask

  task automatic test_abort;
    int n = 0, rd;
    logic [31:0] kt;
    win_en = 0; seed = $urandom; run_len = 20;
    start_key = 24'd0; stride = 24'd1; last_key = 24'd1000; en = 1;
    @(negedge clk); en = 0;
    while (!(keys_tried >= 2 && !a4_rdy) && n < 5000) begin @(negedge clk); n++; end
    @(negedge clk);
    kt = keys_tried;
    abort = 1; @(negedge clk); abort = 0;
    checks += 4;
    if (n >= 5000) begin errors++; $display("FAIL abort_reach_run: timeout %0d cycles", n); end
    if (rdy !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL abort_idle: got rdy %b done %b want 1 1", rdy, done); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL abort_kv: got %b want 0", key_valid); end
    if (keys_tried !== kt)  begin errors++; $display("FAIL abort_tried: got %0d want %0d", keys_tried, kt); end
    run_len = 2; set_win_abc(24'd50);
    run_search(24'd50, 24'd1, 24'd60, rd);
    checks++;
    if (key !== 24'd50 || keys_tried !== 32'd1) begin
      errors++; $display("FAIL after_abort: got key %h tried %0d want 50 1", key, keys_tried);
    end
  endtask

  task automatic test_random;
    int rd, et, n;
    bit ef;
    logic [23:0] s, st, l, ek, se;
    for (int it = 0; it < 10; it++) begin
      seed = $urandom; run_len = $urandom_range(0, 3);
      s  = ($urandom_range(0, 1) != 0) ? 24'($urandom_range(0, 200)) : 24'hFFFFFF - 24'($urandom_range(0, 40));
      st = 24'($urandom_range(0, 5));
      l  = s + 24'($urandom_range(0, 30));
      se = (st == 0) ? 24'd1 : st;
      win_en = ($urandom_range(0, 3) != 0);
      win_key = s + se * 24'($urandom_range(0, 8));
      n = $urandom_range(2, 8);
      win_pt[0] = 8'(n); win_pt[1] = 8'h20; win_pt[n] = 8'h7E;
      for (int i = 2; i < n; i++) win_pt[i] = 8'(32'h20 + $urandom % 95);
      ref_search(s, st, l, ef, ek, et);
      run_search(s, st, l, rd);
      checks += 3;
      if (key_valid !== ef) begin errors++; $display("FAIL rand_kv[%0d]: got %b want %b", it, key_valid, ef); end
      if (key !== ek) begin errors++; $display("FAIL rand_key[%0d]: got %h want %h", it, key, ek); end
      if (keys_tried !== 32'(et)) begin errors++; $display("FAIL rand_tried[%0d]: got %0d want %0d", it, keys_tried, et); end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    win_en = 0; seed = $urandom; run_len = 1;
    start_key = 24'd0; stride = 24'd1; last_key = 24'd1000; en = 1;
    @(negedge clk); en = 0;
    while (!(keys_tried >= 1 && mem_addr != 0 && !rdy) && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst_n = 0; #1;
    checks += 5;
    if (n >= 5000) begin errors++; $display("FAIL rstmid_reach_rd: timeout %0d cycles", n); end
    if (rdy !== 1'b1 || a4_en !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got rdy %b a4_en %b want 1 0", rdy, a4_en); end
    if (keys_tried !== 32'd0) begin errors++; $display("FAIL rstmid_tried: got %0d want 0", keys_tried); end
    if (done !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got done %b kv %b want 0 0", done, key_valid); end
    if (key !== 24'd0) begin errors++; $display("FAIL rstmid_key: got %h want 0", key); end
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_found;
    test_host_read;
    test_exhaust;
    test_stride;
    test_boundaries;
    test_abort;
    test_random;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
